// File: rtl/alu_issue_buffer.sv
// Two-entry elastic buffer between decode and the ALU.
// Decodes aluop/funct3/funct7b5/op5 to alucontrol; valid/ready on both sides.
module alu_issue_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              op5,
  input  logic [DATA_W-1:0] srca,
  input  logic [DATA_W-1:0] srcb,
  input  logic [4:0]        rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alucontrol,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [4:0]        rd_out,
  output logic              illegal
);

  typedef struct packed {
    logic [2:0]        ctl;
    logic              ill;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        rd;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t st, nxt;
  ent_t   h, s, din;
  logic   push, pop;
  logic   wr_h, wr_s, mv;
  logic [2:0] dctl;
  logic       dill;

  always_comb begin
    dctl = 3'b000;
    dill = 1'b0;
    unique case (aluop)
      2'b00: dctl = 3'b000;
      2'b01: dctl = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000: dctl = (op5 & funct7b5) ? 3'b001 : 3'b000;
          3'b001: dctl = 3'b110;
          3'b010: dctl = 3'b101;
          3'b011: dill = 1'b1;
          3'b100: dctl = 3'b100;
          3'b101: begin
            if (funct7b5) dill = 1'b1;
            else          dctl = 3'b111;
          end
          3'b110: dctl = 3'b011;
          3'b111: dctl = 3'b010;
          default: dill = 1'b1;
        endcase
      end
      default: dill = 1'b1;
    endcase
  end

  assign din = '{ctl: dctl, ill: dill, a: srca, b: srcb, rd: rd_in};

  assign in_ready  = (st != FULL);
  assign out_valid = (st != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= EMPTY;
    else          st <= nxt;
  end

  always_comb begin
    nxt  = st;
    wr_h = 1'b0;
    wr_s = 1'b0;
    mv   = 1'b0;
    if (flush) begin
      nxt = EMPTY;
    end else begin
      unique case (st)
        EMPTY: begin
          if (push) begin
            nxt  = ONE;
            wr_h = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            wr_h = 1'b1;
          end else if (push) begin
            nxt  = FULL;
            wr_s = 1'b1;
          end else if (pop) begin
            nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            nxt = ONE;
            mv  = 1'b1;
          end
        end
        default: nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      s <= '0;
    end else begin
      if (wr_h)    h <= din;
      else if (mv) h <= s;
      if (wr_s)    s <= din;
    end
  end

  assign alucontrol = h.ctl;
  assign illegal    = h.ill;
  assign a          = h.a;
  assign b          = h.b;
  assign rd_out     = h.rd;

endmodule
